adding_machine_sequencer: RTL
=============================

Name: adding_machine_sequencer

Overview:
- Controller that sequences a bounded run of the adding machine: fetch N consecutive ROM words from a start index, push them through the one-stage fetch pipeline register, and accumulate them into the sum register.
- Owns the word-index counter. Generates load/clear enables for the pipeline register and the accumulator register.
- Provides a start/busy/done handshake so a higher-level test controller can launch runs back to back.
- The ROM, adder/ALU and registers stay outside this block; it drives only their control inputs and the ROM index.

Parameters:
IDX_W, 30, width of the word index (the byte address is index concatenated with 2'b00)
CNT_W, 16, width of the run length and issued counters

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  launch request, sampled only in IDLE
base_index  in  IDX_W  first ROM word index of the run, captured on an accepted start
count  in  CNT_W  number of words to sum, captured on an accepted start
stall  in  1  freezes the pipeline for the current cycle
rom_index  out  IDX_W  index presented to the ROM
pipe_load  out  1  pipeline register captures ROM data this cycle
acc_load  out  1  accumulator captures accumulator + pipeline register this cycle
acc_clear  out  1  accumulator loads 0 this cycle
busy  out  1  run in progress (every state other than IDLE)
done  out  1  one-cycle pulse at the end of a run
issued  out  CNT_W  words fetched so far in the current run

Behaviour:
- All outputs and registers are registered state or decoded from registered state plus stall. There is no combinational path from start to any output.
- Reset, whether at power-up or mid-run:
  - state goes to IDLE; rom_index, issued, the remaining counter and valid_q go to 0.
  - pipe_load, acc_load, acc_clear, busy and done are all 0.
  - Any run in flight is abandoned and no done pulse is issued.
- States are IDLE, CLEAR, RUN, DRAIN and DONE.
- IDLE:
  - start=1 moves to CLEAR, latches remaining<=count, and sets rom_index<=base_index and issued<=0.
- CLEAR:
  - acc_clear=1 for exactly one cycle; stall does not affect it.
  - Next state is RUN if remaining!=0, otherwise DONE. A zero-length run produces a done pulse with a sum of 0.
- RUN:
  - pipe_load = !stall.
  - On each pipe_load: rom_index<=rom_index+1, issued<=issued+1, remaining<=remaining-1.
  - A pipe_load with remaining==1 moves the state to DRAIN.
- Pipeline valid bit:
  - valid_q <= stall ? valid_q : pipe_load.
  - acc_load = valid_q & !stall, so each word is accumulated exactly once, one unstalled cycle after it is fetched.
- DRAIN:
  - pipe_load=0. The state moves to DONE on the first unstalled cycle, which is the cycle where the last acc_load fires.
- DONE:
  - done=1 for one cycle, then the state returns to IDLE.
  - start is ignored in this state; the earliest relaunch is the following cycle in IDLE.
- start asserted in any state other than IDLE is ignored, and base_index and count are not re-sampled.
- Stall:
  - Holds rom_index, issued, remaining, valid_q and the state in RUN and DRAIN.
  - Forces pipe_load=0 and acc_load=0.
- rom_index wraps modulo 2^IDX_W; no error is flagged. issued never exceeds count.
- Latency with no stall and count=N>0, where cycle 1 is the cycle after start is accepted:
  - cycle 1: CLEAR.
  - cycles 2..N+1: RUN, with pipe_load=1.
  - cycles 3..N+2: acc_load=1.
  - cycle N+2: DRAIN.
  - cycle N+3: done=1.
- Each stall cycle adds exactly one cycle to this timeline.
- busy is 1 from cycle 1 through the done cycle, inclusive.

Test Plan:
- Basic run: ROM words at indices 5,6,7 = 1,2,3; start with base_index=5, count=3.
  - rom_index reads 5,6,7 while pipe_load is high.
  - acc_load is high in cycles 3-5; done=1 in cycle 6.
  - The accumulator model equals 6 and issued=3.
- Zero count: start with count=0.
  - acc_clear=1 in cycle 1, done=1 in cycle 2.
  - pipe_load and acc_load are never asserted; sum=0.
- Stall: the basic run with stall=1 in cycles 3 and 4.
  - rom_index holds at 6 while stalled.
  - done moves to cycle 8; sum is still 6 and no word is double-counted.
- Wrap-around: base_index=30'h3FFFFFFF, count=2.
  - rom_index sequence is 3FFFFFFF then 0; done in cycle 5.
- start while busy: pulse start in cycle 3 with a different base_index and count.
  - The run is unaffected (same sum and done cycle as the basic run) and there is no second launch.
- Mid-run reset: assert reset in cycle 4 of the basic run.
  - The next cycle shows IDLE with all outputs 0 and no done pulse.
  - A fresh start then completes normally.

Source files
------------

// File: rtl/adding_machine_sequencer.sv
// adding_machine_sequencer: sequences a bounded fetch/accumulate run of the adding machine
module adding_machine_sequencer #(
    parameter int IDX_W = 30,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [IDX_W-1:0] base_index,
    input  logic [CNT_W-1:0] count,
    input  logic             stall,
    output logic [IDX_W-1:0] rom_index,
    output logic             pipe_load,
    output logic             acc_load,
    output logic             acc_clear,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
    state_t           r_state;
    logic [IDX_W-1:0] r_rom_index;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_remaining;
    logic             r_valid_q;
    assign pipe_load = (r_state == RUN) && !stall;
    assign acc_load  = r_valid_q && !stall;
    assign acc_clear = r_state == CLEAR;
    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign rom_index = r_rom_index;
    assign issued    = r_issued;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rom_index <= '0;
            r_issued    <= '0;
            r_remaining <= '0;
            r_valid_q   <= 1'b0;
        end else begin
            // valid_q marks a word sitting in the pipeline register awaiting accumulation
            r_valid_q <= stall ? r_valid_q : pipe_load;
            case (r_state)
                IDLE: if (start) begin
                    r_state     <= CLEAR;
                    r_remaining <= count;
                    r_rom_index <= base_index;
                    r_issued    <= '0;
                end
                CLEAR: r_state <= (r_remaining != '0) ? RUN : DONE;
                RUN: if (pipe_load) begin
                    r_rom_index <= r_rom_index + 1'b1;
                    r_issued    <= r_issued + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1)) r_state <= DRAIN;
                end
                DRAIN: if (!stall) r_state <= DONE;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
